mem_arbiter: RTL and testbench

Sequencing controller that shares one word-wide memory bus between the instruction-fetch and data-access ports of the request unit. It accepts fetch and load/store requests from the request unit, grants one at a time, drives a single-outstanding-transaction bus handshake and returns read data with a one-cycle ready pulse per requester. The block sits between the request unit and the memory/bus manager, and is the only master on that bus.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request-unit and memory-bus signals of mem_arbiter; master is the arbiter's view, slave the environment's.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  imem_ren;
    logic [ADDR_W-1:0]     imem_addr;
    logic [DATA_W-1:0]     imem_rdata;
    logic                  i_ready;

    logic                  dmem_ren;
    logic                  dmem_wen;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W/8-1:0]   dmem_sel;
    logic [DATA_W-1:0]     dmem_rdata;
    logic                  d_ready;

    logic                  bus_read;
    logic                  bus_write;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_sel;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_ack;
    logic                  bus_err;

    modport master (
        input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_sel,
        input  bus_rdata, bus_ack,
        output imem_rdata, i_ready, dmem_rdata, d_ready,
        output bus_read, bus_write, bus_addr, bus_wdata, bus_sel, bus_err
    );

    modport slave (
        output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_wdata, dmem_sel,
        output bus_rdata, bus_ack,
        input  imem_rdata, i_ready, dmem_rdata, d_ready,
        input  bus_read, bus_write, bus_addr, bus_wdata, bus_sel, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory bus between fetch and data ports; watchdog built with MEM_ARB_TIMEOUT_EN.
// Latency: strobe 1 cycle after request, ready pulse 1 cycle after bus_ack, 3 cycles minimum per transaction.
// Backpressure: requesters hold their request until ready; the bus cycle waits on bus_ack (or the watchdog).
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.master mif
);
    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
        logic              read;
        logic              write;
    } bus_req_t;

    state_t            state, state_nxt;
    bus_req_t          req, req_nxt;
    logic              last_d, last_d_nxt;
    logic [DATA_W-1:0] irdata, irdata_nxt;
    logic [DATA_W-1:0] drdata, drdata_nxt;
    logic              i_rdy, i_rdy_nxt;
    logic              d_rdy, d_rdy_nxt;
    logic              err, err_nxt;
    logic              d_req, grant_d, timeout;
    logic [DATA_W-1:0] rdata_in;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [CNT_W-1:0] cnt;

    // Counter is zero on entry to a bus state and counts ack-less cycles while there.
    always_ff @(posedge clk) begin
        if (rst || !((state == IBUS) || (state == DBUS))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout  = !mif.bus_ack && ((state == IBUS) || (state == DBUS))
                      && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rdata_in = mif.bus_ack ? mif.bus_rdata : ERR_DATA;
`else
    assign timeout  = 1'b0;
    assign rdata_in = mif.bus_rdata;
`endif

    assign d_req   = mif.dmem_ren | mif.dmem_wen;
    // Data wins a tie unless it also won the previous grant.
    assign grant_d = d_req && (!mif.imem_ren || !last_d);

    always_comb begin
        state_nxt  = state;
        req_nxt    = req;
        last_d_nxt = last_d;
        irdata_nxt = irdata;
        drdata_nxt = drdata;
        i_rdy_nxt  = 1'b0;
        d_rdy_nxt  = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt     = DBUS;
                    last_d_nxt    = 1'b1;
                    req_nxt.addr  = mif.dmem_addr;
                    req_nxt.wdata = mif.dmem_wdata;
                    req_nxt.sel   = mif.dmem_wen ? mif.dmem_sel : {SEL_W{1'b1}};
                    req_nxt.write = mif.dmem_wen;
                    req_nxt.read  = !mif.dmem_wen;
                end else if (mif.imem_ren) begin
                    state_nxt     = IBUS;
                    last_d_nxt    = 1'b0;
                    req_nxt.addr  = mif.imem_addr;
                    req_nxt.wdata = '0;
                    req_nxt.sel   = {SEL_W{1'b1}};
                    req_nxt.write = 1'b0;
                    req_nxt.read  = 1'b1;
                end
            end
            IBUS, DBUS: begin
                if (mif.bus_ack || timeout) begin
                    state_nxt     = DONE;
                    req_nxt.read  = 1'b0;
                    req_nxt.write = 1'b0;
                    err_nxt       = !mif.bus_ack;
                    if (state == IBUS) begin
                        i_rdy_nxt = 1'b1;
                        if (req.read) irdata_nxt = rdata_in;
                    end else begin
                        d_rdy_nxt = 1'b1;
                        if (req.read) drdata_nxt = rdata_in;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req    <= '0;
            last_d <= 1'b0;
            irdata <= '0;
            drdata <= '0;
            i_rdy  <= 1'b0;
            d_rdy  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            req    <= req_nxt;
            last_d <= last_d_nxt;
            irdata <= irdata_nxt;
            drdata <= drdata_nxt;
            i_rdy  <= i_rdy_nxt;
            d_rdy  <= d_rdy_nxt;
            err    <= err_nxt;
        end
    end

    assign mif.bus_read   = req.read;
    assign mif.bus_write  = req.write;
    assign mif.bus_addr   = req.addr;
    assign mif.bus_wdata  = req.wdata;
    assign mif.bus_sel    = req.sel;
    assign mif.bus_err    = err;
    assign mif.imem_rdata = irdata;
    assign mif.dmem_rdata = drdata;
    assign mif.i_ready    = i_rdy;
    assign mif.d_ready    = d_rdy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit running = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus responder: acks after ack_wait wait cycles when enabled; force_ack injects a stray ack.
    int          ack_wait  = 0;
    bit          resp_en   = 1'b0;
    bit          force_ack = 1'b0;
    logic [31:0] resp_data = 32'h0;
    int          wcnt      = 0;

    initial begin
        mif.bus_ack   = 1'b0;
        mif.bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                mif.bus_ack   = 1'b1;
                mif.bus_rdata = resp_data;
            end else if (resp_en && (mif.bus_read || mif.bus_write)) begin
                if (wcnt == ack_wait) begin
                    mif.bus_ack   = 1'b1;
                    mif.bus_rdata = resp_data;
                    wcnt          = 0;
                end else begin
                    mif.bus_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mif.bus_ack = 1'b0;
                wcnt        = 0;
            end
        end
    end

    // Transaction-level model: a transfer is "in flight" while its strobe is expected high.
    logic        m_rd = 0, m_wr = 0, m_ir = 0, m_dr = 0, m_err = 0;
    logic [31:0] m_irdata = 0, m_drdata = 0, m_addr = 0, m_wdata = 0;
    logic [3:0]  m_sel = 0;
    bit          m_isd = 0, m_last_d = 0, m_cool = 0;
    int          m_age = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_rd <= 0; m_wr <= 0; m_ir <= 0; m_dr <= 0; m_err <= 0;
            m_irdata <= 0; m_drdata <= 0; m_addr <= 0; m_wdata <= 0; m_sel <= 0;
            m_isd <= 0; m_last_d <= 0; m_cool <= 0; m_age <= 0;
        end else begin
            m_ir  <= 0;
            m_dr  <= 0;
            m_err <= 0;
            if (m_rd || m_wr) begin
                if (mif.bus_ack || (TO_EN && (m_age + 1 >= TO))) begin
                    m_rd   <= 0;
                    m_wr   <= 0;
                    m_cool <= 1;
                    m_err  <= !mif.bus_ack;
                    if (m_isd) m_dr <= 1; else m_ir <= 1;
                    if (m_rd && m_isd)  m_drdata <= mif.bus_ack ? mif.bus_rdata : 32'hDEADBEEF;
                    if (m_rd && !m_isd) m_irdata <= mif.bus_ack ? mif.bus_rdata : 32'hDEADBEEF;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_cool) begin
                m_cool <= 0;
            end else if ((mif.dmem_ren || mif.dmem_wen) && !(mif.imem_ren && m_last_d)) begin
                m_isd <= 1; m_last_d <= 1; m_age <= 0;
                m_wr <= mif.dmem_wen; m_rd <= !mif.dmem_wen;
                m_addr <= mif.dmem_addr; m_wdata <= mif.dmem_wdata;
                m_sel <= mif.dmem_wen ? mif.dmem_sel : 4'hF;
            end else if (mif.imem_ren) begin
                m_isd <= 0; m_last_d <= 0; m_age <= 0;
                m_rd <= 1; m_wr <= 0;
                m_addr <= mif.imem_addr; m_sel <= 4'hF;
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            chk("bus_read",   mif.bus_read,   m_rd);
            chk("bus_write",  mif.bus_write,  m_wr);
            chk("i_ready",    mif.i_ready,    m_ir);
            chk("d_ready",    mif.d_ready,    m_dr);
            chk("bus_err",    mif.bus_err,    m_err);
            chk("imem_rdata", mif.imem_rdata, m_irdata);
            chk("dmem_rdata", mif.dmem_rdata, m_drdata);
            if (m_rd || m_wr) begin
                chk("bus_addr", mif.bus_addr, m_addr);
                chk("bus_sel",  mif.bus_sel,  m_sel);
            end
            if (m_wr) chk("bus_wdata", mif.bus_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int rd_cnt, rdy_at, err_at, code, pulses;
    logic [31:0] rdata_at;

    initial begin
        mif.imem_ren = 1; mif.imem_addr = 32'h40;
        mif.dmem_ren = 0; mif.dmem_wen = 0; mif.dmem_addr = 0; mif.dmem_wdata = 0; mif.dmem_sel = 0;

        // Reset held two cycles with a fetch pending.
        tick(); tick();
        chk("rst_strobes", {mif.bus_read, mif.bus_write, mif.i_ready, mif.d_ready, mif.bus_err}, 0);
        chk("rst_rdata",   {mif.imem_rdata, mif.dmem_rdata}, 0);
        resp_en = 1; ack_wait = 0; resp_data = 32'h11111111;
        rst = 0;
        tick();
        chk("first_strobe", mif.bus_read, 1);
        tick();
        chk("first_ready", {mif.i_ready, mif.imem_rdata}, {1'b1, 32'h11111111});
        mif.imem_ren = 0;
        tick();

        // Single fetch with three wait cycles.
        mif.imem_ren = 1; mif.imem_addr = 32'h100; ack_wait = 3; resp_data = 32'h00A00093;
        rd_cnt = 0; rdy_at = -1; rdata_at = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (mif.bus_read) rd_cnt++;
            if (mif.i_ready) begin
                rdy_at = c; rdata_at = mif.imem_rdata; mif.imem_ren = 0;
            end
        end
        chk("fetch_strobe_cycles", rd_cnt, 4);
        chk("fetch_ready_cycle", rdy_at, 5);
        chk("fetch_rdata", rdata_at, 32'h00A00093);

        // Contention: fetch, read and write all held, zero-wait acks.
        mif.imem_ren = 1; mif.imem_addr = 32'h400;
        mif.dmem_ren = 1; mif.dmem_wen = 1; mif.dmem_addr = 32'h500;
        mif.dmem_sel = 4'b0101; mif.dmem_wdata = 32'h55AA55AA; ack_wait = 0;
        code = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (mif.bus_write) begin
                code = code * 4 + 1;
                if (code == 1) chk("contention_sel", mif.bus_sel, 4'b0101);
            end else if (mif.bus_read) begin
                code = code * 4 + ((mif.bus_addr == 32'h400) ? 2 : 3);
            end
        end
        chk("contention_order", code, 102);
        mif.imem_ren = 0; mif.dmem_ren = 0; mif.dmem_wen = 0;
        tick();

        // Data read with one wait cycle.
        mif.dmem_ren = 1; mif.dmem_addr = 32'h300; ack_wait = 1; resp_data = 32'hCAFEF00D;
        pulses = 0; rdy_at = -1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (mif.d_ready) begin
                pulses++; rdy_at = c; rdata_at = mif.dmem_rdata; mif.dmem_ren = 0;
            end
        end
        chk("dread_pulses", pulses, 1);
        chk("dread_ready_cycle", rdy_at, 3);
        chk("dread_rdata", rdata_at, 32'hCAFEF00D);

        // Write with ren and wen both high.
        mif.dmem_ren = 1; mif.dmem_wen = 1; mif.dmem_addr = 32'h600;
        mif.dmem_sel = 4'b0011; mif.dmem_wdata = 32'h1234ABCD; ack_wait = 0; resp_data = 32'hFFFFFFFF;
        tick();
        chk("wr_strobes", {mif.bus_write, mif.bus_read}, 2'b10);
        chk("wr_sel_data", {mif.bus_sel, mif.bus_wdata}, {4'b0011, 32'h1234ABCD});
        tick();
        chk("wr_ready_keep", {mif.d_ready, mif.dmem_rdata}, {1'b1, 32'hCAFEF00D});
        mif.dmem_ren = 0; mif.dmem_wen = 0;
        tick();

        // Reset in the middle of a data read, then a stray ack.
        resp_en = 0; mif.dmem_ren = 1; mif.dmem_addr = 32'h700;
        tick(); tick();
        chk("mid_strobe", mif.bus_read, 1);
        rst = 1;
        tick();
        chk("mid_rst_outs", {mif.bus_read, mif.bus_write, mif.d_ready}, 0);
        rst = 0; mif.dmem_ren = 0; force_ack = 1; resp_data = 32'h77777777;
        pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            force_ack = 0;
            if (mif.d_ready || mif.bus_read || mif.bus_write) pulses++;
        end
        chk("late_ack_ignored", pulses, 0);
        chk("late_ack_rdata", mif.dmem_rdata, 0);
        resp_en = 1; ack_wait = 0; resp_data = 32'h0BADF00D; mif.imem_ren = 1; mif.imem_addr = 32'h900;
        tick();
        chk("after_rst_grant", mif.bus_read, 1);
        tick();
        mif.imem_ren = 0;
        tick();

        // Never-acked fetch: watchdog if built in, else an indefinite hold.
        resp_en = 0; mif.imem_ren = 1; mif.imem_addr = 32'h800;
        rd_cnt = 0; rdy_at = -1; err_at = -1; rdata_at = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (mif.bus_read) rd_cnt++;
            if (mif.bus_err) err_at = c;
            if (mif.i_ready) begin
                rdy_at = c; rdata_at = mif.imem_rdata; mif.imem_ren = 0;
            end
        end
        if (TO_EN) begin
            chk("to_strobe_cycles", rd_cnt, TO);
            chk("to_ready_cycle", rdy_at, TO + 1);
            chk("to_err_cycle", err_at, TO + 1);
            chk("to_rdata", rdata_at, 32'hDEADBEEF);
        end else begin
            chk("hold_strobe_cycles", rd_cnt, 20);
            chk("hold_no_err", err_at, -1);
            chk("hold_no_ready", rdy_at, -1);
            rst = 1; mif.imem_ren = 0;
            tick();
            rst = 0;
            tick();
        end

        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
